seq_pattern_gen: RTL and testbench

- Stimulus-side counterpart to the team's sequence-checking blocks: drives the sequence those blocks check.
- On a start request it emits the pattern $rose(c) with e in the same cycle, then a after GAP1 cycles, then b after GAP2 more cycles. This is the consequent shape "e ##G1 (a ##G2 b)".
- Sits in the bench/DUT stimulus layer and feeds c, e, a, b into the checkers.
- Supports per-run gap programming, deliberate error injection, and a run counter.

---
 rtl/seq_gen_pkg.sv | 23 ++
 rtl/seq_pattern_gen_gap_counter.sv | 32 +++
 rtl/seq_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the sequence pattern generator.
package seq_gen_pkg;

    // Largest gap, in cycles, the generator can be programmed with by default.
    localparam int MAX_GAP_DEFAULT = 15;

    // Generator phases, in the order a run walks through them.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_WAIT1,
        S_FIRE_A,
        S_WAIT2,
        S_FIRE_B,
        S_DONE
    } state_t;

    // A programmed gap of 0 would put two terms in the same cycle; run it as 1.
    function automatic int unsigned clamp_gap(input int unsigned gap);
        return (gap == 0) ? 1 : gap;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_gap_counter.sv
// Down-counter shared by both wait phases: load a start value, count down,
// and flag the cycle in which the wait phase should hand over to the next term.
module gap_counter
    import seq_gen_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; the two never coincide in practice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // Terminal when one cycle of waiting is left.
    assign term = (count_reg <= W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Drives the pattern rose(c)&e ##g1 a ##g2 b, one run per accepted start,
// with per-run gap programming, optional suppression of b, and a run counter.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_GAP = MAX_GAP_DEFAULT,
    parameter int GAP_W   = $clog2(MAX_GAP + 1),
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [GAP_W-1:0] cfg_gap1,
    input  logic [GAP_W-1:0] cfg_gap2,
    input  logic             inject_err,
    output logic             busy,
    output logic             done,
    output logic             err_injected,
    output logic             c,
    output logic             e,
    output logic             a,
    output logic             b,
    output logic [CNT_W-1:0] seq_count
);

    state_t             state_reg, state_next;
    logic [GAP_W-1:0]   g1_reg, g1_next;
    logic [GAP_W-1:0]   g2_reg, g2_next;
    logic               err_reg, err_next;

    logic               c_reg, c_next;
    logic               e_reg, e_next;
    logic               a_reg, a_next;
    logic               b_reg, b_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_inj_reg, err_inj_next;
    logic [CNT_W-1:0]   seq_count_reg, seq_count_next;

    logic               cnt_load;
    logic [GAP_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_term;

    gap_counter #(
        .W (GAP_W)
    ) u_gap_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    // Next state, latched run configuration, counter control and next outputs.
    always_comb begin
        state_next   = state_reg;
        g1_next      = g1_reg;
        g2_next      = g2_reg;
        err_next     = err_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_HEAD;
                    g1_next    = GAP_W'(clamp_gap(32'(cfg_gap1)));
                    g2_next    = GAP_W'(clamp_gap(32'(cfg_gap2)));
                    err_next   = inject_err;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HEAD: begin
                if (g1_reg == GAP_W'(1)) begin
                    state_next = S_FIRE_A;
                end else begin
                    state_next   = S_WAIT1;
                    cnt_load     = 1'b1;
                    cnt_load_val = g1_reg - GAP_W'(1);
                end
            end
            S_WAIT1: begin
                if (cnt_term) begin
                    state_next = S_FIRE_A;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_FIRE_A: begin
                if (g2_reg == GAP_W'(1)) begin
                    state_next = S_FIRE_B;
                end else begin
                    state_next   = S_WAIT2;
                    cnt_load     = 1'b1;
                    cnt_load_val = g2_reg - GAP_W'(1);
                end
            end
            S_WAIT2: begin
                if (cnt_term) begin
                    state_next = S_FIRE_B;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_FIRE_B: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so that they come
        // straight out of flops and line up with that state.
        c_next         = (state_next == S_HEAD);
        e_next         = (state_next == S_HEAD);
        a_next         = (state_next == S_FIRE_A);
        b_next         = (state_next == S_FIRE_B) && !err_reg;
        busy_next      = (state_next inside {S_HEAD, S_WAIT1, S_FIRE_A, S_WAIT2, S_FIRE_B});
        done_next      = (state_next == S_DONE);
        err_inj_next   = (state_next == S_DONE) && err_reg;
        seq_count_next = (state_next == S_DONE) ? seq_count_reg + CNT_W'(1) : seq_count_reg;
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            g1_reg        <= GAP_W'(1);
            g2_reg        <= GAP_W'(1);
            err_reg       <= 1'b0;
            c_reg         <= 1'b0;
            e_reg         <= 1'b0;
            a_reg         <= 1'b0;
            b_reg         <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_inj_reg   <= 1'b0;
            seq_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            g1_reg        <= g1_next;
            g2_reg        <= g2_next;
            err_reg       <= err_next;
            c_reg         <= c_next;
            e_reg         <= e_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_inj_reg   <= err_inj_next;
            seq_count_reg <= seq_count_next;
        end
    end

    assign c            = c_reg;
    assign e            = e_reg;
    assign a            = a_reg;
    assign b            = b_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err_injected = err_inj_reg;
    assign seq_count    = seq_count_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench: stimulus pushes hand-computed run expectations, a monitor
// measures each run relative to the rise of c and compares on every done.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] cfg_gap1;
    logic [3:0] cfg_gap2;
    logic       inject_err;
    logic       busy, done, err_injected, c, e, a, b;
    logic [7:0] seq_count;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .MAX_GAP (15),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_gap1     (cfg_gap1),
        .cfg_gap2     (cfg_gap2),
        .inject_err   (inject_err),
        .busy         (busy),
        .done         (done),
        .err_injected (err_injected),
        .c            (c),
        .e            (e),
        .a            (a),
        .b            (b),
        .seq_count    (seq_count)
    );

    typedef struct {
        int         a_off;
        int         b_off;     // -1: b must never pulse
        int         done_off;
        logic       err;
        logic [7:0] cnt;
        logic       chained;   // head must follow the previous done directly
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   head_cyc = 0, last_done_cyc = -100, head_gap = 0;
    int   a_off = -1, b_off = -1, busy_cnt = 0, c_cycles = 0, overlap = 0, head_ok = 0;
    logic c_prev = 1'b0;

    always @(negedge clk) begin
        exp_t ex;
        if (c && !c_prev) begin
            head_cyc = cyc;
            head_gap = cyc - last_done_cyc;
            a_off    = -1;
            b_off    = -1;
            busy_cnt = 0;
            c_cycles = 0;
            overlap  = 0;
            head_ok  = e ? 1 : 0;
        end
        if (c) c_cycles++;
        if (a) a_off = cyc - head_cyc;
        if (b) b_off = cyc - head_cyc;
        if (busy) busy_cnt++;
        if (int'(e) + int'(a) + int'(b) > 1) overlap++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                ex = exp_q.pop_front();
                check("head_c_e",  head_ok, 1);
                check("c_width",   c_cycles, 1);
                check("a_offset",  a_off, ex.a_off);
                check("b_offset",  b_off, ex.b_off);
                check("done_off",  cyc - head_cyc, ex.done_off);
                check("busy_cyc",  busy_cnt, ex.done_off);
                check("overlap",   overlap, 0);
                check("err_inj",   int'(err_injected), int'(ex.err));
                check("seq_count", int'(seq_count), int'(ex.cnt));
                if (ex.chained) check("b2b_gap", head_gap, 1);
                $display("run: a@+%0d b@+%0d done@+%0d err=%0b count=%0d",
                         a_off, b_off, cyc - head_cyc, err_injected, seq_count);
            end
            head_ok       = 0;
            last_done_cyc = cyc;
        end
        c_prev = c;
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int ea, input int eb, input int ed,
                            input logic err, input logic chained);
        exp_t ex;
        exp_count = exp_count + 8'd1;
        ex.a_off = ea; ex.b_off = eb; ex.done_off = ed;
        ex.err = err; ex.cnt = exp_count; ex.chained = chained;
        exp_q.push_back(ex);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    // nruns > 1 keeps start held so runs chain through DONE.
    task automatic run_seq(input logic [3:0] g1, input logic [3:0] g2, input logic err,
                           input int nruns, input int ea, input int eb, input int ed);
        int seen = 0;
        int n    = 0;
        @(negedge clk);
        cfg_gap1 = g1; cfg_gap2 = g2; inject_err = err; start = 1'b1;
        for (int i = 0; i < nruns; i++) push_exp(ea, eb, ed, err, (i > 0));
        while (seen < nruns && n < nruns * 40 + 50) begin
            @(negedge clk);
            n++;
            if (nruns == 1) start = 1'b0;
            if (done) begin
                seen++;
                if (seen == nruns) start = 1'b0;
            end
        end
        start = 1'b0;
        if (seen < nruns) check("run_timeout", seen, nruns);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_gap1 = 4'd2; cfg_gap2 = 4'd2; inject_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_c",     int'(c), 0);
        check("rst_count", int'(seq_count), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // defaults: gaps 2,2
        run_seq(4'd2, 4'd2, 1'b0, 1, 2, 4, 5);
        // three chained runs with gaps 1,5
        run_seq(4'd1, 4'd5, 1'b0, 3, 1, 6, 7);
        // zero gaps run as 1,1
        run_seq(4'd0, 4'd0, 1'b0, 1, 1, 2, 3);
        // error injection suppresses b
        run_seq(4'd3, 4'd2, 1'b1, 1, 3, -1, 6);

        // start re-pulsed and config changed mid-run: latched gaps 4,3 hold
        @(negedge clk);
        cfg_gap1 = 4'd4; cfg_gap2 = 4'd3; inject_err = 1'b0; start = 1'b1;
        push_exp(4, 7, 8, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0; cfg_gap1 = 4'd1; cfg_gap2 = 4'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(40);
        repeat (4) @(negedge clk);
        check("no_restart_busy", int'(busy), 0);

        // reset during WAIT2 clears everything without a clock edge
        @(negedge clk);
        cfg_gap1 = 4'd2; cfg_gap2 = 4'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("async_busy",  int'(busy), 0);
        check("async_c",     int'(c | e | a | b), 0);
        check("async_done",  int'(done | err_injected), 0);
        check("async_count", int'(seq_count), 0);
        exp_count = 8'd0;
        @(negedge clk); reset = 1'b0;
        run_seq(4'd2, 4'd2, 1'b0, 1, 2, 4, 5);

        // counter wrap: 256 chained runs from a fresh reset end at 0
        @(negedge clk); reset = 1'b1;
        exp_count = 8'd0;
        @(negedge clk); reset = 1'b0;
        run_seq(4'd1, 4'd1, 1'b0, 256, 1, 2, 3);
        check("wrap_count", int'(seq_count), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
